// File: rtl/display_pkg.sv
// Shared constants and parser state encoding for the display RAM write path.
package display_pkg;

  localparam int ADDR_WIDTH = 11;
  localparam logic [7:0] SYNC_BYTE = 8'h2A;
  // A LEN byte of zero encodes the largest packet, 256 payload bytes.
  localparam logic [8:0] LEN_ZERO_COUNT = 9'd256;

  typedef enum logic [2:0] {
    IDLE,
    AHI,
    ALO,
    LEN,
    DWAIT,
    UNPACK
  } loaderStateT;

endpackage

// File: rtl/byte_unpacker.sv
// Holds one payload byte and presents it as four 2-bit pixels, MSB pair first.
module byte_unpacker (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       load,
  input  logic [7:0] loadByte,
  input  logic       advance,
  output logic [1:0] pair,
  output logic       lastPair
);

  logic [7:0] shift;
  logic [1:0] pairCnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      shift   <= 8'h00;
      pairCnt <= 2'd0;
    end else if (load) begin
      shift   <= loadByte;
      pairCnt <= 2'd0;
    end else if (advance) begin
      shift   <= {shift[5:0], 2'b00};
      pairCnt <= pairCnt + 2'd1;
    end
  end

  assign pair     = shift[7:6];
  assign lastPair = (pairCnt == 2'd3);

endmodule

// File: rtl/framebuffer_loader.sv
// Parses SYNC/ADDR_HI/ADDR_LO/LEN packets and streams the payload into the
// 2-bit display RAM, four pixels per byte.
//
//   state  | meaning
//   IDLE   | hunting for the sync byte
//   AHI    | expecting the high address byte
//   ALO    | expecting the low address byte
//   LEN    | expecting the payload length
//   DWAIT  | waiting for the next payload byte
//   UNPACK | writing the four pixels of the current byte
module framebuffer_loader
  import display_pkg::*;
#(
  parameter int         ADDR_WIDTH     = display_pkg::ADDR_WIDTH,
  parameter logic [7:0] SYNC_BYTE      = display_pkg::SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [7:0]            InData,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [1:0]            RamData,
  output logic [ADDR_WIDTH-1:0] RamAddr,
  output logic                  RamWr,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err
);

  localparam int HI_BITS = ADDR_WIDTH - 8;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  loaderStateT           state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [8:0]            remaining;
  logic [TW-1:0]         timeoutCnt;
  logic                  armed;
  logic                  lastWrite;
  logic                  accept;
  logic                  headerPhase;
  logic                  timedOut;
  logic [1:0]            pairData;
  logic                  lastPair;

  // armed keeps InReady low for the cycle following reset.
  assign headerPhase = (state == AHI) || (state == ALO) || (state == LEN) || (state == DWAIT);
  assign InReady     = armed && ((state == IDLE) || headerPhase ||
                                 ((state == UNPACK) && lastPair && (remaining != 9'd1)));
  assign accept      = InValid && InReady;
  assign timedOut    = headerPhase && !accept && (timeoutCnt == TOUT_LAST);

  byte_unpacker unpacker (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (accept && ((state == DWAIT) || (state == UNPACK))),
    .loadByte (InData),
    .advance  (state == UNPACK),
    .pair     (pairData),
    .lastPair (lastPair)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      timeoutCnt <= '0;
      armed      <= 1'b0;
      RamWr      <= 1'b0;
      RamData    <= 2'b00;
      RamAddr    <= '0;
      Busy       <= 1'b0;
      lastWrite  <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
    end else begin
      armed      <= 1'b1;
      RamWr      <= (state == UNPACK);
      RamData    <= pairData;
      RamAddr    <= addr;
      Busy       <= (state != IDLE);
      Done       <= lastWrite;
      lastWrite  <= 1'b0;
      Err        <= 1'b0;
      timeoutCnt <= (headerPhase && !accept) ? timeoutCnt + 1'b1 : '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (InData == SYNC_BYTE) state <= AHI;
            else Err <= 1'b1;
          end
        end
        AHI: begin
          if (accept) begin
            if (InData[7:HI_BITS] == '0) begin
              addr[ADDR_WIDTH-1:8] <= InData[HI_BITS-1:0];
              state <= ALO;
            end else begin
              Err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        ALO: begin
          if (accept) begin
            addr[7:0] <= InData;
            state     <= LEN;
          end
        end
        LEN: begin
          if (accept) begin
            remaining <= (InData == 8'd0) ? LEN_ZERO_COUNT : {1'b0, InData};
            state     <= DWAIT;
          end
        end
        DWAIT: begin
          if (accept) state <= UNPACK;
        end
        UNPACK: begin
          addr <= addr + 1'b1;
          if (lastPair) begin
            remaining <= remaining - 9'd1;
            if (remaining == 9'd1) begin
              state     <= IDLE;
              lastWrite <= 1'b1;
            end else if (!accept) begin
              state <= DWAIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (timedOut) begin
        Err   <= 1'b1;
        state <= IDLE;
      end
    end
  end

endmodule

// File: doc/framebuffer_loader.md
# framebuffer_loader

Packet-driven write stage that sits directly upstream of the 2-bit × 2048 display RAM and drives its write port. It consumes a byte stream from the serial receiver, parses a small header (sync byte, start address, length) and unpacks each payload byte into four consecutive 2-bit RAM writes. Header errors and stalled packets are detected and reported, and the block always returns to a clean idle state.

## Interface

Parameters:
- ADDR_WIDTH, 11: RAM word address width. 2048 entries of 2 bits each.
- SYNC_BYTE, 8'h2A: packet start marker.
- TIMEOUT_CYCLES, 1_000_000: maximum idle gap between bytes inside a packet before the packet is aborted.

Ports:
- Clock, input, 1: single clock. The RAM write clock is tied to it.
- Reset, input, 1: synchronous, active-high.
- InData, input, 8: incoming byte.
- InValid, input, 1: InData is valid.
- InReady, output, 1: the block accepts the byte this cycle. A transfer happens when InValid and InReady are both high.
- RamData, output, 2: write data to the RAM.
- RamAddr, output, ADDR_WIDTH: write address to the RAM.
- RamWr, output, 1: write enable, active high.
- Busy, output, 1: high in any state other than IDLE.
- Done, output, 1: one-cycle pulse after the last pair of a packet has been written.
- Err, output, 1: one-cycle pulse on a bad sync byte, a bad address byte or a timeout.

Reset values: InReady=0, RamData=0, RamAddr=0, RamWr=0, Busy=0, Done=0, Err=0. State is IDLE and all counters are cleared.

## Operation

Packet format: SYNC, ADDR_HI, ADDR_LO, LEN, then payload bytes.
- ADDR_HI[2:0] gives address bits [10:8]. ADDR_HI[7:3] must be 0.
- LEN is the payload byte count, 1..255. LEN=0 means 256.

States:
- IDLE: InReady=1.
  - On accepting SYNC_BYTE, go to AHI.
  - On any other byte, pulse Err and stay in IDLE.
- AHI: InReady=1.
  - On accept with byte[7:3]==0, load addr[10:8] and go to ALO.
  - Otherwise pulse Err and go to IDLE.
- ALO: InReady=1. On accept, load addr[7:0] and go to LEN.
- LEN: InReady=1. On accept, load remaining = (byte==0 ? 256 : byte), a 9-bit value, and go to DWAIT.
- DWAIT: InReady=1. On accept, load shift register = byte, set pair counter to 0 and go to UNPACK.
- UNPACK:
  - RamWr=1, RamData=shift[7:6], RamAddr=addr.
  - Every cycle: shift <<= 2, addr += 1, pair += 1.
  - At pair==3: decrement remaining. Then:
    - If remaining becomes 0: go to IDLE and pulse Done on the next cycle.
    - Otherwise, InReady=1 in this same cycle. If a byte is accepted, reload shift, set pair=0 and stay in UNPACK with no gap. If no byte is accepted, go to DWAIT.
  - InReady=0 at pair 0..2.

Rules:
- Address arithmetic is modulo 2^ADDR_WIDTH: 2047 wraps to 0 with no error.
- Pixel order within a byte: bits [7:6] first, [1:0] last.
- Timeout: a counter runs in AHI, ALO, LEN and DWAIT and clears on every accepted byte. When it reaches TIMEOUT_CYCLES-1: pulse Err and go to IDLE. Any partially written payload stays in the RAM.
- The timeout counter is not active in UNPACK or IDLE.
- Reset asserted mid-packet: all outputs take their reset values on the next edge and no further writes are issued.

## Timing

- Accepted byte at edge k: the first RamWr cycle is k+1, and the four writes occupy cycles k+1..k+4.
- Sustained throughput is 1 byte per 4 cycles. With back-to-back input, RamWr stays high for the whole packet: 4·LEN cycles.
- Done is high in the cycle immediately after the final write. Busy drops in that same cycle.
- Err is a 1-cycle pulse, registered, in the cycle after the offending accept or the timeout expiry.
- RamAddr, RamData and RamWr are driven from registers, with no combinational path from InData.
- InReady in UNPACK depends only on internal state, never on InValid.

## Structure

- Shared package `display_pkg`:
  - `ADDR_WIDTH`
  - `SYNC_BYTE`
  - the state enum (IDLE, AHI, ALO, LEN, DWAIT, UNPACK)
  - the LEN=0 → 256 decode constant
- One sub-module is natural: `byte_unpacker`, which holds the 8-bit shift register and the 2-bit pair counter and produces the pair output plus a last_pair flag.
- The parser FSM, address counter and timeout counter stay in the top module.

## Test plan

- Packet 2A 00 10 02 E4 1B → eight writes at 0x010..0x017 with data 3,2,1,0,0,1,2,3. Done pulses one cycle after the write to 0x017, and RamWr is continuous.
- Packet 2A 07 FF 01 C0 → writes 3,0,0,0 at 0x7FF, 0x000, 0x001, 0x002, confirming address wrap.
- Byte 55 in IDLE → Err pulse and no write. A following 2A 08 … → Err pulse on the 08 (bad ADDR_HI) and return to IDLE.
- LEN=00 with 256 payload bytes → exactly 1024 writes and a single Done. InReady is high only on pair 3 during UNPACK.
- Header 2A 00 00 03, one payload byte, then silence for TIMEOUT_CYCLES (set to 16 in the bench) → 4 writes, Err pulse 16 cycles after DWAIT is entered, Busy returns to 0 and no Done.
- Reset asserted on the second pair of an unpacking byte → RamWr is 0 from the next edge onward. A subsequent valid packet is parsed correctly.
